// File: rtl/cv32e40x_xif_offload_pkg.sv
// Shared configuration, types and helpers for the XIF offload initiator slice.
package cv32e40x_xif_offload_pkg;

    localparam int unsigned X_ID_WIDTH      = 4;
    localparam int unsigned X_RFR_WIDTH     = 32;
    localparam int unsigned X_RFW_WIDTH     = 32;
    localparam int unsigned MAX_OUTSTANDING = 4;

    localparam int unsigned CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SLOT_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam int unsigned RD_FIELD_LSB = 7;
    localparam int unsigned RD_FIELD_MSB = 11;

    typedef logic [CNT_WIDTH-1:0]  cnt_t;
    typedef logic [SLOT_WIDTH-1:0] slot_t;
    typedef logic [X_ID_WIDTH-1:0] xid_t;

    typedef struct packed {
        logic       valid;
        xid_t       id;
        logic [4:0] rd;
        logic       writeback;
        logic       committed;
    } entry_t;

    // Circular increment over table slots, safe for non power-of-two depths.
    function automatic slot_t slot_inc(slot_t p);
        return (p == slot_t'(MAX_OUTSTANDING - 1)) ? '0 : p + slot_t'(1);
    endfunction

endpackage

// File: rtl/cv32e40x_xif_offload_if.sv
// XIF issue/commit/result channel bundle between core (master) and coprocessor (slave).
interface cv32e40x_xif_offload_if;
    import cv32e40x_xif_offload_pkg::*;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [31:0]              issue_instr;
    xid_t                     issue_id;
    logic [2*X_RFR_WIDTH-1:0] issue_rs;
    logic [1:0]               issue_rs_valid;
    logic                     issue_accept;
    logic                     issue_writeback;

    logic                     commit_valid;
    xid_t                     commit_id;
    logic                     commit_kill;

    logic                     result_valid;
    logic                     result_ready;
    xid_t                     result_id;
    logic [X_RFW_WIDTH-1:0]   result_data;
    logic [4:0]               result_rd;
    logic                     result_we;

    modport master (
        output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        output commit_valid, commit_id, commit_kill,
        output result_ready,
        input  issue_ready, issue_accept, issue_writeback,
        input  result_valid, result_id, result_data, result_rd, result_we
    );

    modport slave (
        input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        input  commit_valid, commit_id, commit_kill,
        input  result_ready,
        output issue_ready, issue_accept, issue_writeback,
        output result_valid, result_id, result_data, result_rd, result_we
    );

endinterface

// File: rtl/cv32e40x_xif_offload_table.sv
// Outstanding-offload table: slot allocation, in-order commit order, result lookup,
// full flag and per-register busy bits.
module cv32e40x_xif_offload_table
    import cv32e40x_xif_offload_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_alloc,
    input  xid_t        i_alloc_id,
    input  logic [4:0]  i_alloc_rd,
    input  logic        i_alloc_wb,

    input  logic        i_commit,
    input  logic        i_commit_kill,
    output logic        o_commit_hit_c,
    output xid_t        o_commit_id_c,

    input  logic        i_res,
    input  xid_t        i_res_id,
    output logic        o_res_hit_c,

    output logic        o_full_c,
    output logic [31:0] o_rd_busy
);

    entry_t [MAX_OUTSTANDING-1:0] r_ent;
    entry_t [MAX_OUTSTANDING-1:0] w_ent_nxt;
    slot_t  [MAX_OUTSTANDING-1:0] r_ord;
    slot_t                        r_ord_head;
    slot_t                        r_ord_tail;
    cnt_t                         r_count;
    cnt_t                         r_unc_count;
    logic [31:0]                  r_rd_busy;

    slot_t       w_commit_slot;
    slot_t       w_res_slot;
    slot_t       w_free_slot;
    logic        w_do_commit;
    int          w_n_free;
    cnt_t        w_count_nxt;
    cnt_t        w_unc_nxt;
    logic [31:0] w_busy_nxt;

    assign o_full_c  = (r_count == cnt_t'(MAX_OUTSTANDING));
    assign o_rd_busy = r_rd_busy;

    // Next table contents from commit, result free and allocation in this cycle.
    always_comb begin
        w_ent_nxt      = r_ent;
        w_n_free       = 0;
        w_commit_slot  = r_ord[r_ord_head];
        o_commit_hit_c = (r_unc_count != '0);
        o_commit_id_c  = r_ent[w_commit_slot].id;
        w_do_commit    = i_commit && o_commit_hit_c;

        o_res_hit_c = 1'b0;
        w_res_slot  = '0;
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (r_ent[i].valid && r_ent[i].committed && (r_ent[i].id == i_res_id)) begin
                o_res_hit_c = 1'b1;
                w_res_slot  = slot_t'(i);
            end
        end

        w_free_slot = '0;
        for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
            if (!r_ent[i].valid) begin
                w_free_slot = slot_t'(i);
            end
        end

        // Killed or no-writeback entries retire at commit; others wait for a result.
        if (w_do_commit) begin
            if (i_commit_kill || !r_ent[w_commit_slot].writeback) begin
                w_ent_nxt[w_commit_slot].valid = 1'b0;
                w_n_free++;
            end else begin
                w_ent_nxt[w_commit_slot].committed = 1'b1;
            end
        end

        if (i_res && o_res_hit_c) begin
            w_ent_nxt[w_res_slot].valid = 1'b0;
            w_n_free++;
        end

        if (i_alloc) begin
            w_ent_nxt[w_free_slot] = '{valid: 1'b1, id: i_alloc_id, rd: i_alloc_rd,
                                       writeback: i_alloc_wb, committed: 1'b0};
        end

        w_count_nxt = cnt_t'(int'(r_count) + int'(i_alloc) - w_n_free);
        w_unc_nxt   = cnt_t'(int'(r_unc_count) + int'(i_alloc) - int'(w_do_commit));
    end

    // Busy bits follow the next-state table, so a same-cycle set beats a clear.
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (w_ent_nxt[i].valid && w_ent_nxt[i].writeback) begin
                w_busy_nxt[w_ent_nxt[i].rd] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent       <= '0;
            r_ord       <= '0;
            r_ord_head  <= '0;
            r_ord_tail  <= '0;
            r_count     <= '0;
            r_unc_count <= '0;
            r_rd_busy   <= '0;
        end else begin
            r_ent       <= w_ent_nxt;
            r_count     <= w_count_nxt;
            r_unc_count <= w_unc_nxt;
            r_rd_busy   <= w_busy_nxt;
            if (i_alloc) begin
                r_ord[r_ord_tail] <= w_free_slot;
                r_ord_tail        <= slot_inc(r_ord_tail);
            end
            if (w_do_commit) begin
                r_ord_head <= slot_inc(r_ord_head);
            end
        end
    end

endmodule

// File: rtl/cv32e40x_xif_offload.sv
// Core-side XIF initiator: issue register, commit forwarding and result write-back
// into the register file, backed by the outstanding-offload table.
module cv32e40x_xif_offload
    import cv32e40x_xif_offload_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [31:0]            instr_i,
    input  logic [X_RFR_WIDTH-1:0] rs1_i,
    input  logic [X_RFR_WIDTH-1:0] rs2_i,
    input  logic [1:0]             rs_valid_i,

    output logic                   offload_accepted_o,
    output logic                   offload_rejected_o,

    input  logic                   commit_valid_i,
    input  logic                   commit_kill_i,

    output logic [31:0]            rd_busy_o,

    output logic                   rf_we_o,
    output logic [4:0]             rf_waddr_o,
    output logic [X_RFW_WIDTH-1:0] rf_wdata_o,
    input  logic                   rf_wready_i,

    output logic                   protocol_err_o,

    cv32e40x_xif_offload_if.master xif
);

    logic                     r_active;
    logic                     r_issue_valid;
    logic [31:0]              r_issue_instr;
    xid_t                     r_issue_id;
    logic [2*X_RFR_WIDTH-1:0] r_issue_rs;
    logic [1:0]               r_issue_rs_valid;
    xid_t                     r_id_cnt;

    logic                     r_commit_valid;
    xid_t                     r_commit_id;
    logic                     r_commit_kill;

    logic                     r_wb_valid;
    logic                     r_wb_we;
    logic [4:0]               r_wb_rd;
    logic [X_RFW_WIDTH-1:0]   r_wb_data;
    logic                     r_protocol_err;

    logic w_full;
    logic w_instr_hs;
    logic w_issue_hs;
    logic w_res_hs;
    logic w_res_hit;
    logic w_result_ready;
    logic w_commit_hit;
    xid_t w_commit_id;

    // Readies are held low until the first clock after reset release.
    assign instr_ready_o  = r_active && !r_issue_valid && !w_full;
    assign w_instr_hs     = instr_valid_i && instr_ready_o;
    assign w_issue_hs     = r_issue_valid && xif.issue_ready;
    assign w_result_ready = r_active && (!r_wb_valid || rf_wready_i);
    assign w_res_hs       = xif.result_valid && w_result_ready;

    assign offload_accepted_o = w_issue_hs && xif.issue_accept;
    assign offload_rejected_o = w_issue_hs && !xif.issue_accept;

    assign xif.issue_valid    = r_issue_valid;
    assign xif.issue_instr    = r_issue_instr;
    assign xif.issue_id       = r_issue_id;
    assign xif.issue_rs       = r_issue_rs;
    assign xif.issue_rs_valid = r_issue_rs_valid;
    assign xif.commit_valid   = r_commit_valid;
    assign xif.commit_id      = r_commit_id;
    assign xif.commit_kill    = r_commit_kill;
    assign xif.result_ready   = w_result_ready;

    assign rf_we_o        = r_wb_valid && r_wb_we;
    assign rf_waddr_o     = r_wb_rd;
    assign rf_wdata_o     = r_wb_data;
    assign protocol_err_o = r_protocol_err;

    cv32e40x_xif_offload_table u_table (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_alloc        (w_issue_hs && xif.issue_accept),
        .i_alloc_id     (r_issue_id),
        .i_alloc_rd     (r_issue_instr[RD_FIELD_MSB:RD_FIELD_LSB]),
        .i_alloc_wb     (xif.issue_writeback),
        .i_commit       (commit_valid_i),
        .i_commit_kill  (commit_kill_i),
        .o_commit_hit_c (w_commit_hit),
        .o_commit_id_c  (w_commit_id),
        .i_res          (w_res_hs),
        .i_res_id       (xif.result_id),
        .o_res_hit_c    (w_res_hit),
        .o_full_c       (w_full),
        .o_rd_busy      (rd_busy_o)
    );

    // Issue register and ID counter; the counter advances on every issue handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active         <= 1'b0;
            r_issue_valid    <= 1'b0;
            r_issue_instr    <= '0;
            r_issue_id       <= '0;
            r_issue_rs       <= '0;
            r_issue_rs_valid <= '0;
            r_id_cnt         <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_instr_hs) begin
                r_issue_valid    <= 1'b1;
                r_issue_instr    <= instr_i;
                r_issue_id       <= r_id_cnt;
                r_issue_rs       <= {rs2_i, rs1_i};
                r_issue_rs_valid <= rs_valid_i;
            end else if (w_issue_hs) begin
                r_issue_valid <= 1'b0;
            end
            if (w_issue_hs) begin
                r_id_cnt <= r_id_cnt + xid_t'(1);
            end
        end
    end

    // One-cycle commit transaction for the oldest uncommitted entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_valid <= 1'b0;
            r_commit_id    <= '0;
            r_commit_kill  <= 1'b0;
        end else begin
            r_commit_valid <= commit_valid_i && w_commit_hit;
            r_commit_id    <= (commit_valid_i && w_commit_hit) ? w_commit_id : '0;
            r_commit_kill  <= commit_valid_i && w_commit_hit && commit_kill_i;
        end
    end

    // Write-back register holds a result until the register file accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_we        <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_res_hs && w_res_hit) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= xif.result_we;
                r_wb_rd    <= xif.result_rd;
                r_wb_data  <= xif.result_data;
            end else if (rf_wready_i) begin
                r_wb_valid <= 1'b0;
            end
            r_protocol_err <= w_res_hs && !w_res_hit;
        end
    end

endmodule

// File: doc/cv32e40x_xif_offload.md
# cv32e40x_xif_offload

Core-side initiator of the eXtension interface (XIF): accepts an offload candidate from the core pipeline, drives the XIF issue handshake, forwards in-order commit/kill decisions, and receives coprocessor results into the register-file write port. Sits between the core's execute stage and any XIF coprocessor, such as the AES unit. Tracks outstanding offloads in a small table and exports per-register busy bits for hazard stalls.

## Interface
- X_ID_WIDTH, 4, width of the XIF instruction ID
- X_RFR_WIDTH, 32, width of source operands
- X_RFW_WIDTH, 32, width of result data
- MAX_OUTSTANDING, 4, outstanding-table depth; must be ≤ 2^X_ID_WIDTH and ≥ 1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid_i / instr_ready_o  in/out  1  pipeline offload request handshake
- instr_i  in  32  instruction word
- rs1_i, rs2_i  in  X_RFR_WIDTH  operands; rs_valid_i  in  2  operand-valid bits
- offload_accepted_o, offload_rejected_o  out  1  one-cycle pulses on XIF issue handshake
- commit_valid_i, commit_kill_i  in  1  pipeline commit decision for the oldest accepted, uncommitted offload
- rd_busy_o  out  32  per-rd pending-writeback bits; bit 0 is always 0
- rf_we_o  out  1, rf_waddr_o  out  5, rf_wdata_o  out  X_RFW_WIDTH, rf_wready_i  in  1: register-file write port
- protocol_err_o  out  1  one-cycle pulse on an illegal result
- x_issue_valid_o  out  1, x_issue_ready_i  in  1, x_issue_instr_o  out  32, x_issue_id_o  out  X_ID_WIDTH, x_issue_rs_o  out  2×X_RFR_WIDTH, x_issue_rs_valid_o  out  2
- x_issue_accept_i, x_issue_writeback_i  in  1  issue response, sampled on the issue handshake
- x_commit_valid_o  out  1, x_commit_id_o  out  X_ID_WIDTH, x_commit_kill_o  out  1
- x_result_valid_i  in  1, x_result_ready_o  out  1, x_result_id_i  in  X_ID_WIDTH, x_result_data_i  in  X_RFW_WIDTH, x_result_rd_i  in  5, x_result_we_i  in  1

## Operation
- Issue register:
  - A pipeline handshake captures the request fields and the current ID counter.
  - x_issue_valid_o rises on the next cycle.
  - The issue register holds all x_issue_* outputs stable until x_issue_ready_i.
- instr_ready_o = !issue_valid_q && table not full. The table counts as full at MAX_OUTSTANDING entries.
- On the issue handshake, the ID counter increments modulo 2^X_ID_WIDTH, including for rejected instructions.
- Accepted issue (accept=1):
  - Allocate a table entry {id, rd=instr[11:7], writeback, committed=0}.
  - Pulse offload_accepted_o.
  - If writeback=1 and rd≠0, set rd_busy_o[rd].
- Rejected issue (accept=0): pulse offload_rejected_o. No table entry is allocated and no commit is sent.
- Commit:
  - commit_valid_i applies to the oldest entry with committed=0, tracked by an in-order commit pointer.
  - A registered commit transaction is driven next cycle: x_commit_valid_o is a one-cycle pulse with the entry id and kill=commit_kill_i.
  - commit_valid_i with no uncommitted entry is ignored.
- After commit:
  - kill=1, or writeback=0: the entry is freed in the commit cycle and its rd_busy bit is cleared.
  - kill=0 with writeback=1: the entry is marked committed and awaits its result.
- Result:
  - x_result_ready_o = !wb_valid_q || rf_wready_i.
  - On the handshake, look up x_result_id_i among committed entries. On a hit, capture {rd, data, we} into the write-back register, free the entry, and clear its rd_busy bit.
  - rf_we_o = wb_valid_q && we_q. Both x_result_rd_i and x_result_we_i must be honoured.
  - A result whose id does not match a committed entry (unknown, killed, or uncommitted id) is consumed, dropped, and pulses protocol_err_o.
- Simultaneous events:
  - If rd_busy set (new issue) and clear (completion) hit the same rd in the same cycle, the set wins.
  - Commit and result for different entries in the same cycle are both processed.
  - Issue allocation and result free in the same cycle keep the table count unchanged.
- Reset values: all outputs 0, table empty, ID counter 0.

## Timing
- Pipeline handshake to x_issue_valid_o: 1 cycle.
- Issue handshake to offload_accepted_o/offload_rejected_o: same cycle, combinational on the response.
- commit_valid_i to x_commit_valid_o: 1 cycle.
- Result handshake to rf_we_o: 1 cycle; the value is held until rf_wready_i.
- rd_busy_o updates on the clock edge after the triggering handshake.
- Maximum sustained issue rate is one offload per 2 cycles, because the issue register has no bypass.

## Structure
- Package cv32e40x_xif_offload_pkg holds:
  - the entry struct {valid, id, rd, writeback, committed};
  - the count typedef sized $clog2(MAX_OUTSTANDING+1);
  - the RD_FIELD_LSB/MSB constants.
- Sub-module cv32e40x_xif_offload_table implements the outstanding table:
  - allocate, commit-pointer, id-lookup and free logic;
  - the full flag;
  - rd_busy generation.

## Test plan
- Issue instr 0x0000_0533 (rd=10) with rs=0x11,0x22 → x_issue_valid_o 1 cycle later with id 0; on accept=1, writeback=1, rd_busy_o[10]=1.
- Commit kill=0, then result id 0 with data 0xDEADBEEF → x_commit_valid_o id 0, kill 0; rf_we_o with waddr 10, data 0xDEADBEEF; rd_busy_o[10]=0.
- Issue 4 accepted offloads without commit → instr_ready_o=0 after the 4th; IDs 0..3. Commit + result for the first → ready returns.
- Issue accept=0 → offload_rejected_o pulse; no x_commit; next issue uses the next ID (counter advanced).
- Commit kill=1 on an outstanding entry, then the coprocessor returns a result with that id → entry freed at commit; result consumed, protocol_err_o pulses, rf_we_o stays 0.
- Assert rst_n low while 2 entries are outstanding and the write-back register is valid → all outputs 0 immediately; after release, the first issue uses id 0.
